// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock acquisition retry and lock-loss supervision
//
// Runs from the PLL reference clock (not a PLL output), so it keeps working
// while the PLL is held in reset or has lost lock.
//
// Sequence: pulse pll_rst, wait for lock (with timeout and bounded retries),
// require lock to stay continuously high for LOCK_STABLE_CYC cycles, then
// release sys_rst. A loss of lock while running re-resets the PLL and
// reasserts sys_rst. Exhausting the retries parks the block in FAIL until rst.
//
// Ports:
//   clk         in   reference clock (same net as PLL clkin1)
//   rst         in   asynchronous active-high reset
//   pll_lock    in   PLL lock indication, asynchronous to clk
//   pll_rst     out  PLL reset, active-high
//   sys_rst     out  downstream system reset, active-high (low only in RUN)
//   locked      out  high while in RUN
//   fail        out  high in FAIL (terminal)
//   retry_cnt   out  [7:0] acquisition timeouts in the current acquisition
//   loss_cnt    out  [7:0] saturating count of lock losses since rst
//   loss_pulse  out  one-cycle pulse per lock loss detected in RUN
//
// Build option:
//   PLL_SUP_LOSS_FILTER_EN  when defined, a loss of lock in RUN must persist
//                           for LOSS_FILTER_CYC consecutive cycles; shorter
//                           dropouts are ignored. When undefined, any single
//                           low cycle of the synchronized lock is a loss.

module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int MAX_RETRY        = 3,
    parameter int LOSS_FILTER_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic       loss_pulse
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYC - 1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);

    state_t      state;
    logic [31:0] cnt;
    logic        lock_meta;
    logic        lock_s;
    logic        loss_event;
    logic [7:0]  retry_next;

    assign retry_next = retry_cnt + 8'd1;

    // Two-flop synchronizer for the asynchronous PLL lock output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

`ifdef PLL_SUP_LOSS_FILTER_EN
    localparam logic [31:0] FILTER_LAST = 32'(LOSS_FILTER_CYC - 1);

    logic [31:0] filt_cnt;

    // The filter counter counts consecutive low cycles while running; the
    // loss fires on the cycle that would complete the run of LOSS_FILTER_CYC.
    assign loss_event = ~lock_s && (filt_cnt == FILTER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
        end else if (state != S_RUN || lock_s || loss_event) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 32'd1;
        end
    end
`else
    // Unfiltered: any low cycle of the synchronized lock is a loss. The
    // filter length only matters in the filtered build and is >= 1 by
    // contract, so this term is constant true.
    assign loss_event = ~lock_s & (LOSS_FILTER_CYC > 0);
`endif

    // Main FSM. The Moore outputs are registered copies decoded from the
    // current state, so they follow a state change by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RESET_PLL;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            locked     <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
            loss_pulse <= 1'b0;
        end else begin
            pll_rst    <= (state == S_RESET_PLL);
            sys_rst    <= (state != S_RUN);
            locked     <= (state == S_RUN);
            fail       <= (state == S_FAIL);
            loss_pulse <= 1'b0;

            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt       <= '0;
                        retry_cnt <= retry_next;
                        state     <= (retry_next == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_STABLE: begin
                    // A dropout restarts the timeout window but is not
                    // counted as a retry.
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        retry_cnt <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_RUN: begin
                    if (loss_event) begin
                        state      <= S_RESET_PLL;
                        cnt        <= '0;
                        loss_pulse <= 1'b1;
                        loss_cnt   <= (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                    end
                end

                S_FAIL: begin
                    state <= S_FAIL;
                end

                default: begin
                    state <= S_RESET_PLL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor

module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       locked;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic       loss_pulse;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_lc = 8'd0;

`ifdef PLL_SUP_LOSS_FILTER_EN
    localparam int REACT = 6;
`else
    localparam int REACT = 3;
`endif

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(32),
        .MAX_RETRY       (2),
        .LOSS_FILTER_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .locked    (locked),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .loss_pulse(loss_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lock;
        int         ticks;
        logic       prst;
        logic       srst;
        logic       lk;
        logic       fl;
        logic [7:0] rc;
        logic [7:0] lc;
        logic       lp;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input int r, input int l, input int t, input int p,
                                input int s, input int k, input int f,
                                input int rc, input int lc, input int lp);
        vec_t v;
        v.rst   = r[0];
        v.lock  = l[0];
        v.ticks = t;
        v.prst  = p[0];
        v.srst  = s[0];
        v.lk    = k[0];
        v.fl    = f[0];
        v.rc    = rc[7:0];
        v.lc    = lc[7:0];
        v.lp    = lp[0];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        rst      = v.rst;
        pll_lock = v.lock;
        if (v.ticks == 0) #1;
        else tick(v.ticks);
        chk1($sformatf("v%0d pll_rst", idx), pll_rst, v.prst);
        chk1($sformatf("v%0d sys_rst", idx), sys_rst, v.srst);
        chk1($sformatf("v%0d locked", idx), locked, v.lk);
        chk1($sformatf("v%0d fail", idx), fail, v.fl);
        chk8($sformatf("v%0d retry_cnt", idx), retry_cnt, v.rc);
        chk8($sformatf("v%0d loss_cnt", idx), loss_cnt, v.lc);
        chk1($sformatf("v%0d loss_pulse", idx), loss_pulse, v.lp);
    endtask

    // Drop pll_lock for len cycles starting from RUN; the loss is expected
    // to be acted on react edges after the drop starts, then the PLL is
    // re-reset and the block re-enters RUN with lock held.
    task automatic do_drop(input int len, input int react);
        pll_lock = 1'b0;
        for (int i = 1; i <= react + 1; i++) begin
            tick(1);
            if (i < react) begin
                chk1("drop quiet loss_pulse", loss_pulse, 1'b0);
                chk1("drop quiet sys_rst", sys_rst, 1'b0);
            end else if (i == react) begin
                exp_lc = (exp_lc == 8'hFF) ? exp_lc : exp_lc + 8'd1;
                chk1("loss_pulse high", loss_pulse, 1'b1);
                chk8("loss_cnt", loss_cnt, exp_lc);
            end else begin
                chk1("loss_pulse one cycle", loss_pulse, 1'b0);
                chk1("sys_rst reasserted", sys_rst, 1'b1);
                chk1("pll_rst after loss", pll_rst, 1'b1);
                chk1("locked after loss", locked, 1'b0);
            end
            if (i == len) pll_lock = 1'b1;
        end
        tick(3);
        chk1("pll_rst pulse last cycle", pll_rst, 1'b1);
        tick(1);
        chk1("pll_rst pulse end", pll_rst, 1'b0);
        tick(8);
        chk1("relock sys_rst held", sys_rst, 1'b1);
        tick(1);
        chk1("relock sys_rst release", sys_rst, 1'b0);
        chk1("relock locked", locked, 1'b1);
    endtask

    initial begin
        //           rst lock ticks prst srst lk fl rc lc lp
        // Nominal lock
        vecs[0]  = mk(1, 0, 2,  1, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 4,  1, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1,  0, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 10, 0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 11, 0, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1,  0, 0, 1, 0, 0, 0, 0);
        // Timeout, retry and FAIL
        vecs[6]  = mk(1, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 5,  0, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 30, 0, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
        vecs[10] = mk(0, 0, 1,  1, 1, 0, 0, 1, 0, 0);
        vecs[11] = mk(0, 0, 3,  1, 1, 0, 0, 1, 0, 0);
        vecs[12] = mk(0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
        vecs[13] = mk(0, 0, 31, 0, 1, 0, 0, 2, 0, 0);
        vecs[14] = mk(0, 0, 1,  0, 1, 0, 1, 2, 0, 0);
        vecs[15] = mk(0, 1, 20, 0, 1, 0, 1, 2, 0, 0);
        // Unstable lock
        vecs[16] = mk(1, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 5,  0, 1, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 1, 5,  0, 1, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 5,  0, 1, 0, 0, 0, 0, 0);
        vecs[20] = mk(0, 1, 11, 0, 1, 0, 0, 0, 0, 0);
        vecs[21] = mk(0, 1, 1,  0, 0, 1, 0, 0, 0, 0);
        // Mid-operation reset during STABLE at count 5
        vecs[22] = mk(1, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        vecs[23] = mk(0, 1, 10, 0, 1, 0, 0, 0, 0, 0);
        vecs[24] = mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 4,  1, 1, 0, 0, 0, 0, 0);
        vecs[26] = mk(0, 0, 1,  0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i <= 5; i++) run_vec(i);

        // Loss of lock in RUN
`ifdef PLL_SUP_LOSS_FILTER_EN
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk1("glitch loss_pulse", loss_pulse, 1'b0);
            chk1("glitch sys_rst", sys_rst, 1'b0);
            chk8("glitch loss_cnt", loss_cnt, 8'd0);
        end
        do_drop(4, REACT);
`else
        do_drop(1, REACT);
`endif

        // Saturation of loss_cnt
        for (int k = 0; k < 260; k++) do_drop(4, REACT);
        chk8("loss_cnt saturated", loss_cnt, 8'd255);

        for (int i = 6; i <= 26; i++) run_vec(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
